// File: rtl/gfx_bank_arbiter_pkg.sv
// Shared types and constants for the four-port graphics SDRAM bank arbiter.
package gfx_bank_arbiter_pkg;

  localparam int NPORTS    = 4;
  localparam int DW        = 32;

  localparam int PORT_SPR  = 0;
  localparam int PORT_SCR0 = 1;
  localparam int PORT_SCR1 = 2;
  localparam int PORT_SCR2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DATA0 = 2'd2,
    ST_DATA1 = 2'd3
  } state_t;

  // Round-robin successor within the scroll ports 1..3.
  function automatic logic [1:0] next_scr(input logic [1:0] p);
    return (p == 2'(PORT_SCR2)) ? 2'(PORT_SCR0) : p + 2'd1;
  endfunction

endpackage

// File: rtl/gfx_bank_prio.sv
// Grant selector: starved ports first (lowest index), then sprite, then round-robin over scroll ports.
module gfx_bank_prio
  import gfx_bank_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NPORTS-1:0] pending_i,
  input  logic [NPORTS-1:0] starved_i,
  input  logic              take_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic              gnt_vld_o
);

  logic [1:0]        ptr_q, ptr_d;
  logic [NPORTS-1:0] urgent;
  logic [1:0]        cand;
  logic              found;

  always_comb begin
    gnt_o  = '0;
    urgent = pending_i & starved_i;
    cand   = ptr_q;
    found  = 1'b0;
    if (urgent != '0) begin
      gnt_o = urgent & (~urgent + NPORTS'(1));
    end else if (pending_i[PORT_SPR]) begin
      gnt_o[PORT_SPR] = 1'b1;
    end else begin
      for (int k = 0; k < NPORTS - 1; k++) begin
        if (!found && pending_i[cand]) begin
          gnt_o[cand] = 1'b1;
          found       = 1'b1;
        end
        cand = next_scr(cand);
      end
    end
    gnt_vld_o = |gnt_o;

    // Pointer follows any scroll-port winner, whichever rule picked it.
    ptr_d = ptr_q;
    if (take_i) begin
      for (int n = PORT_SCR0; n <= PORT_SCR2; n++) begin
        if (gnt_o[n]) ptr_d = next_scr(2'(n));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 2'(PORT_SCR0);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gfx_bank_arbiter.sv
// Four-port SDRAM read arbiter with a one-entry cache per port; hits answer combinationally,
// misses are serialised as double-word bank reads.
module gfx_bank_arbiter
  import gfx_bank_arbiter_pkg::*;
#(
  parameter int SDRAMW     = 22,
  parameter int AW         = 22,
  parameter int STARVE_MAX = 15
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NPORTS-1:0]    REQ_CS,
  input  logic [NPORTS*AW-1:0] REQ_ADDR,
  output logic [NPORTS-1:0]    REQ_OK,
  output logic [NPORTS*DW-1:0] REQ_DOUT,
  output logic [SDRAMW-1:0]    SDRAM_ADDR,
  output logic                 SDRAM_REQ,
  input  logic                 SDRAM_ACK,
  input  logic                 DATA_DST,
  input  logic                 DATA_RDY,
  input  logic [15:0]          DATA_READ
);

  localparam int            CW   = 4;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [SDRAMW-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic [15:0]         buf_q, buf_d;
  logic [NPORTS-1:0]   valid_q, valid_d;
  logic [AW-2:0]       tag_q   [NPORTS];
  logic [AW-2:0]       tag_d   [NPORTS];
  logic [DW-1:0]       data_q  [NPORTS];
  logic [DW-1:0]       data_d  [NPORTS];
  logic [CW-1:0]       starve_q[NPORTS];
  logic [CW-1:0]       starve_d[NPORTS];

  logic [AW-1:0]       addr_a  [NPORTS];
  logic [NPORTS-1:0]   hit, pending, starved, gnt_oh;
  logic [NPORTS-1:0]   unused_addr_lsb;
  logic                gnt_vld, take;
  logic [1:0]          gnt_idx;

  always_comb begin
    REQ_DOUT = '0;
    for (int n = 0; n < NPORTS; n++) begin
      addr_a[n]          = REQ_ADDR[n*AW +: AW];
      unused_addr_lsb[n] = addr_a[n][0];
      hit[n]     = REQ_CS[n] & valid_q[n] & (addr_a[n][AW-1:1] == tag_q[n]);
      // The port in flight is not pending even if its address moved; it re-requests after the fill.
      pending[n] = REQ_CS[n] & ~hit[n] & ~((state_q != ST_IDLE) && (gnt_q == 2'(n)));
      starved[n] = (starve_q[n] == SMAX);
      REQ_DOUT[n*DW +: DW] = data_q[n];
    end
  end

  assign REQ_OK     = hit;
  assign SDRAM_ADDR = addr_q;
  assign SDRAM_REQ  = req_q;
  assign take       = (state_q == ST_IDLE) && gnt_vld;

  gfx_bank_prio u_prio (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .pending_i (pending),
    .starved_i (starved),
    .take_i    (take),
    .gnt_o     (gnt_oh),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    gnt_idx = '0;
    for (int n = 0; n < NPORTS; n++) begin
      if (gnt_oh[n]) gnt_idx = 2'(n);
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    req_d    = req_q;
    buf_d    = buf_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    data_d   = data_q;
    starve_d = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          gnt_d   = gnt_idx;
          addr_d  = SDRAMW'({addr_a[gnt_idx][AW-1:1], 1'b0});
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (SDRAM_ACK) begin
          req_d   = 1'b0;
          state_d = ST_DATA0;
        end
      end
      ST_DATA0: begin
        if (DATA_DST && DATA_RDY) begin
          // Protocol error: both halves take this beat and the fill completes anyway.
          data_d[gnt_q]  = {DATA_READ, DATA_READ};
          tag_d[gnt_q]   = addr_q[AW-1:1];
          valid_d[gnt_q] = 1'b1;
          state_d        = ST_IDLE;
        end else if (DATA_DST) begin
          buf_d   = DATA_READ;
          state_d = ST_DATA1;
        end
      end
      ST_DATA1: begin
        if (DATA_RDY) begin
          data_d[gnt_q]  = {buf_q, DATA_READ};
          tag_d[gnt_q]   = addr_q[AW-1:1];
          valid_d[gnt_q] = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int n = 0; n < NPORTS; n++) begin
      if (!REQ_CS[n]) begin
        starve_d[n] = '0;
      end else if (take) begin
        if (gnt_oh[n])                             starve_d[n] = '0;
        else if (pending[n] && starve_q[n] != SMAX) starve_d[n] = starve_q[n] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      buf_q   <= '0;
      valid_q <= '0;
      for (int n = 0; n < NPORTS; n++) begin
        tag_q[n]    <= '0;
        data_q[n]   <= '0;
        starve_q[n] <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      buf_q    <= buf_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: doc/gfx_bank_arbiter.md
Name: gfx_bank_arbiter

Overview:
- Shares one SDRAM read bank between four 32-bit graphics requesters: sprite plus scroll layers 0-2.
- Each port has a one-entry cache (address tag plus data). Hits are answered from registers; misses are queued and serviced one at a time as double-word SDRAM reads.
- Sits between the GP9001 fetch ports and the SDRAM controller's bank-1 interface.

Parameters:
- SDRAMW, 22, SDRAM word-address width.
- AW, 22, requester address width (16-bit word address, bit 0 ignored).
- STARVE_MAX, 15, number of grants a pending port may lose before it is forced to win (4-bit counter).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- REQ_CS  in  4  per-port read request (port 0 = sprite, ports 1-3 = scroll 0-2)
- REQ_ADDR  in  4*AW  flattened addresses, port n at [n*AW +: AW]
- REQ_OK  out  4  per-port data valid for the current address
- REQ_DOUT  out  128  flattened data, port n at [n*32 +: 32]
- SDRAM_ADDR  out  SDRAMW  word address of the active fetch
- SDRAM_REQ  out  1  read request to the controller
- SDRAM_ACK  in  1  controller accepted the request
- DATA_DST  in  1  first data word present on DATA_READ
- DATA_RDY  in  1  second (last) data word present on DATA_READ
- DATA_READ  in  16  SDRAM read data

Behaviour:
- Reset values: all outputs 0, all cache valid bits 0, all starvation counters 0, FSM in IDLE, round-robin pointer on port 1.
- Hit: REQ_OK[n] = REQ_CS[n] & valid[n] & (REQ_ADDR[n][AW-1:1] == tag[n]). This is combinational from registers, so a hit gives 0-cycle latency.
- Miss: pending[n] = REQ_CS[n] & ~hit[n]. The port cannot be pending while it is being serviced.
- FSM states: IDLE, REQ, DATA0, DATA1.
  - IDLE: if any port is pending, grant one. Latch gnt and the address with bit 0 forced to 0. Next cycle: SDRAM_REQ=1, state REQ.
  - REQ: hold SDRAM_REQ and SDRAM_ADDR until SDRAM_ACK. On the ACK cycle, drop SDRAM_REQ and go to DATA0.
  - DATA0: on DATA_DST, capture DATA_READ into buf[31:16], go to DATA1.
  - DATA1: on DATA_RDY, write {buf[31:16], DATA_READ} into data[gnt], write the latched address into tag[gnt], set valid[gnt], go to IDLE.
  - The new data is visible to the OK logic the cycle after DATA_RDY. The next grant can be issued in that same cycle.
- Minimum miss latency, counted from CS rising to OK high: 1 (grant) + the controller's ACK/DST/RDY latency + 1.
- Arbitration priority:
  1. Any pending port whose starvation counter equals STARVE_MAX, lowest index first.
  2. Otherwise port 0 if pending.
  3. Otherwise round-robin over ports 1-3, starting from the pointer. The pointer moves to the port after the winner.
- Starvation counter: increments, saturating at STARVE_MAX, each time another port is granted while this port is pending. It clears when this port is granted or when its CS is low.
- Boundary conditions:
  - Address changes while its own fetch is in flight: the fetch completes and the cache stores the old address. The port then misses and re-requests, so stale data is never flagged OK.
  - CS drops mid-fetch: the fetch completes and the cache is filled; REQ_OK stays 0 while CS is low.
  - DATA_DST or DATA_RDY arriving in IDLE or REQ: ignored.
  - DATA_DST and DATA_RDY in the same cycle while in DATA0: treated as a protocol error. Both words take that cycle's DATA_READ, and the FSM returns to IDLE.
  - RESET mid-transfer: FSM returns to IDLE and valid bits clear. Late DST/RDY pulses from the aborted transfer are ignored by the rule above.
  - All four ports miss simultaneously from reset: service order is 0, 1, 2, 3.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/REQ/DATA0/DATA1, 2 bits)
  - port index constants (PORT_SPR=0, PORT_SCR0..2=1..3)
  - NPORTS=4 and DW=32
- Natural sub-module: gfx_bank_prio, a combinational plus pointer-register grant selector. Inputs: pending and starved vectors. Outputs: one-hot grant and a valid flag.

Test Plan:
1. After RESET, REQ_CS=4'b0001, addr0=22'h000100; controller ACKs 2 cycles after REQ, DST then RDY with 16'hAAAA, 16'h5555 -> SDRAM_ADDR=22'h000100, REQ_DOUT[31:0]=32'hAAAA5555, REQ_OK[0]=1 the cycle after RDY; repeating the same address gives OK with no SDRAM_REQ.
2. All four CS rise together with distinct addresses -> grant order 0,1,2,3; each port's OK and data match its own fetch.
3. Port 0 misses continuously on incrementing addresses while port 2 is pending -> port 2 is granted after exactly STARVE_MAX=15 port-0 grants.
4. Port 1 changes address from 22'h10 to 22'h20 during DATA0 -> no OK for 22'h20 using 22'h10 data; a second fetch to 22'h20 follows immediately.
5. RESET asserted in DATA1, and the controller then emits a stray RDY -> all outputs 0, all valid bits cleared, the stray RDY ignored; the next miss proceeds normally.
6. DST pulse in IDLE, plus CS dropped mid-fetch -> no state change from the DST; the cache fills while REQ_OK stays 0, and when CS reasserts with the same address, OK=1 with no new SDRAM_REQ.
